// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and constants for the PWM channel core.
//   pwm_state_e : channel FSM state (PWM_IDLE, PWM_RUN)
//   PWM_CNT_W   : width of the period counter and prescaler
//   PWM_SCALE_W : width of the prescale exponent
package pwm_pkg;

  localparam int unsigned PWM_CNT_W   = 16;
  localparam int unsigned PWM_SCALE_W = 4;

  typedef enum logic {
    PWM_IDLE,
    PWM_RUN
  } pwm_state_e;

  // Terminal prescaler value for a given exponent: 2^scale - 1.
  function automatic logic [PWM_CNT_W-1:0] scale_mask(input logic [PWM_SCALE_W-1:0] scale);
    return (PWM_CNT_W'(1) << scale) - PWM_CNT_W'(1);
  endfunction

endpackage

// File: rtl/pwm_prescale.sv
// pwm_prescale: divides mclk by 2^scale while enabled.
//   mclk      in  system clock
//   h_reset_n in  asynchronous active-low reset
//   enable_i  in  count enable; when low the counter is held at 0
//   scale_i   in  prescale exponent
//   tick_o    out one-cycle strobe when the counter reaches 2^scale-1
module pwm_prescale
  import pwm_pkg::*;
(
  input  logic                   mclk,
  input  logic                   h_reset_n,
  input  logic                   enable_i,
  input  logic [PWM_SCALE_W-1:0] scale_i,
  output logic                   tick_o
);

  logic [PWM_CNT_W-1:0] pre_q, pre_d;

  assign tick_o = enable_i && (pre_q == scale_mask(scale_i));

  always_comb begin
    pre_d = '0;
    if (enable_i && !tick_o) begin
      pre_d = pre_q + PWM_CNT_W'(1);
    end
  end

  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/pwm_core.sv
// pwm_core: one PWM channel with prescaler, shadowed period/high settings,
// one-shot mode and output inversion.
//   mclk, h_reset_n    clock, asynchronous active-low reset
//   cfg_pwm_enb/run    channel enable and run request (both needed to run)
//   cfg_pwm_dupdate    1 = keep shadows at period boundary
//   cfg_pwm_oneshot    stop after one period
//   cfg_pwm_inv        invert waveform
//   cfg_pwm_scale      tick every 2^scale mclk
//   cfg_pwm_period     terminal count (period+1 ticks)
//   cfg_pwm_high       high-phase length in ticks
//   pwm_wfm            registered waveform
//   pwm_os_done        one-cycle pulse at one-shot completion
//   pwm_ovflow         one-cycle pulse after each counter wrap
module pwm_core
  import pwm_pkg::*;
(
  input  logic                   mclk,
  input  logic                   h_reset_n,
  input  logic                   cfg_pwm_enb,
  input  logic                   cfg_pwm_run,
  input  logic                   cfg_pwm_dupdate,
  input  logic                   cfg_pwm_oneshot,
  input  logic                   cfg_pwm_inv,
  input  logic [PWM_SCALE_W-1:0] cfg_pwm_scale,
  input  logic [PWM_CNT_W-1:0]   cfg_pwm_period,
  input  logic [PWM_CNT_W-1:0]   cfg_pwm_high,
  output logic                   pwm_wfm,
  output logic                   pwm_os_done,
  output logic                   pwm_ovflow
);

  pwm_state_e             st_q, st_d;
  logic [PWM_CNT_W-1:0]   cnt_q, cnt_d;
  logic [PWM_CNT_W-1:0]   per_q, per_d;
  logic [PWM_CNT_W-1:0]   high_q, high_d;
  logic [PWM_SCALE_W-1:0] scale_q, scale_d;
  logic                   os_q, os_d;
  logic                   inv_q, inv_d;
  logic                   wfm_q, wfm_d;
  logic                   ovf_q, ovf_d;
  logic                   osd_q, osd_d;
  logic                   go;
  logic                   tick;
  logic                   load;

  assign go = cfg_pwm_enb && cfg_pwm_run;

  // Prescaler runs only while staying in RUN; an abort clears it on the same edge.
  pwm_prescale u_prescale (
    .mclk      (mclk),
    .h_reset_n (h_reset_n),
    .enable_i  ((st_q == PWM_RUN) && go),
    .scale_i   (scale_q),
    .tick_o    (tick)
  );

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    high_d  = high_q;
    scale_d = scale_q;
    os_d    = os_q;
    inv_d   = inv_q;
    ovf_d   = 1'b0;
    osd_d   = 1'b0;
    load    = 1'b0;

    case (st_q)
      PWM_IDLE: begin
        cnt_d = '0;
        if (go) begin
          st_d = PWM_RUN;
          load = 1'b1;
        end
      end
      PWM_RUN: begin
        if (!go) begin
          st_d  = PWM_IDLE;
          cnt_d = '0;
        end else if (tick) begin
          if (cnt_q == per_q) begin
            cnt_d = '0;
            ovf_d = 1'b1;
            if (os_q) begin
              osd_d = 1'b1;
              st_d  = PWM_IDLE;
            end else if (!cfg_pwm_dupdate) begin
              load = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + PWM_CNT_W'(1);
          end
        end
      end
      default: st_d = PWM_IDLE;
    endcase

    if (load) begin
      per_d   = cfg_pwm_period;
      high_d  = cfg_pwm_high;
      scale_d = cfg_pwm_scale;
      os_d    = cfg_pwm_oneshot;
      inv_d   = cfg_pwm_inv;
    end

    // Waveform is computed from the post-edge count/shadows so it is registered
    // without an extra cycle of lag.
    if (st_d == PWM_RUN) begin
      wfm_d = (cnt_d < high_d) ^ inv_d;
    end else begin
      wfm_d = cfg_pwm_inv;
    end
  end

  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      st_q    <= PWM_IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      high_q  <= '0;
      scale_q <= '0;
      os_q    <= 1'b0;
      inv_q   <= 1'b0;
      wfm_q   <= 1'b0;
      ovf_q   <= 1'b0;
      osd_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      high_q  <= high_d;
      scale_q <= scale_d;
      os_q    <= os_d;
      inv_q   <= inv_d;
      wfm_q   <= wfm_d;
      ovf_q   <= ovf_d;
      osd_q   <= osd_d;
    end
  end

  assign pwm_wfm     = wfm_q;
  assign pwm_ovflow  = ovf_q;
  assign pwm_os_done = osd_q;

endmodule
